// File: rtl/sync_chain_sequencer.sv
// sync_chain_sequencer
// Divides CLK_DRV into the pixel clock PIX_CLK_N that drives the toggle
// flip-flop counter stages. Keeps a registered H/V master count that steps on
// every PIX_CLK_N fall, and registers the sync, blank and frame strobes from it.
// Optional macro SYNC_SERRATION_EN: when defined, COMP_SYNC_N is HSYNC_N XNOR
// VSYNC_N (serrated vsync). When undefined, it is HSYNC_N AND VSYNC_N.

module sync_chain_sequencer #(
  parameter int unsigned DIV          = 2,
  parameter int unsigned H_TOTAL      = 454,
  parameter int unsigned H_ACTIVE     = 384,
  parameter int unsigned H_SYNC_START = 400,
  parameter int unsigned H_SYNC_LEN   = 32,
  parameter int unsigned V_TOTAL      = 262,
  parameter int unsigned V_ACTIVE     = 240,
  parameter int unsigned V_SYNC_START = 244,
  parameter int unsigned V_SYNC_LEN   = 4
) (
  input  logic       CLK_DRV,
  input  logic       RST_N,
  input  logic       ENABLE,
  output logic       PIX_CLK_N,
  output logic       PIX_CE,
  output logic [8:0] H_CNT,
  output logic [8:0] V_CNT,
  output logic       HSYNC_N,
  output logic       VSYNC_N,
  output logic       HBLANK,
  output logic       VBLANK,
  output logic       COMP_SYNC_N,
  output logic       FRAME_START
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);

  logic [DW-1:0] div_cnt;
  logic          fall;
  logic [8:0]    h_next;
  logic [8:0]    v_next;
  logic          hsync_n_next;
  logic          vsync_n_next;
  logic          hblank_next;
  logic          vblank_next;
  logic          comp_sync_n_next;

  // Find the fall edge, then work out the next counts and the decodes for them
  always_comb begin
    fall   = ENABLE && PIX_CLK_N && (div_cnt == DIV_LAST);
    h_next = H_CNT + 9'd1;
    v_next = V_CNT;
    if (H_CNT == H_LAST) begin
      h_next = '0;
      v_next = (V_CNT == V_LAST) ? 9'd0 : V_CNT + 9'd1;
    end
    hsync_n_next = !(({23'd0, h_next} >= H_SYNC_START) &&
                     ({23'd0, h_next} <  H_SYNC_START + H_SYNC_LEN));
    vsync_n_next = !(({23'd0, v_next} >= V_SYNC_START) &&
                     ({23'd0, v_next} <  V_SYNC_START + V_SYNC_LEN));
    hblank_next  = ({23'd0, h_next} >= H_ACTIVE);
    vblank_next  = ({23'd0, v_next} >= V_ACTIVE);
`ifdef SYNC_SERRATION_EN
    comp_sync_n_next = ~(hsync_n_next ^ vsync_n_next);
`else
    comp_sync_n_next = hsync_n_next & vsync_n_next;
`endif
  end

  // Pixel clock divider; holds its phase while ENABLE is low
  always_ff @(posedge CLK_DRV or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt   <= '0;
      PIX_CLK_N <= 1'b1;
    end else if (ENABLE) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt   <= '0;
        PIX_CLK_N <= ~PIX_CLK_N;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  // One-cycle strobes: the pixel enable and the start-of-frame marker
  always_ff @(posedge CLK_DRV or negedge RST_N) begin
    if (!RST_N) begin
      PIX_CE      <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      PIX_CE      <= fall;
      FRAME_START <= fall && (h_next == 9'd0) && (v_next == 9'd0);
    end
  end

  // On each fall, step the master count and register the matching decodes
  always_ff @(posedge CLK_DRV or negedge RST_N) begin
    if (!RST_N) begin
      H_CNT       <= '0;
      V_CNT       <= '0;
      HSYNC_N     <= 1'b1;
      VSYNC_N     <= 1'b1;
      HBLANK      <= 1'b0;
      VBLANK      <= 1'b0;
      COMP_SYNC_N <= 1'b1;
    end else if (fall) begin
      H_CNT       <= h_next;
      V_CNT       <= v_next;
      HSYNC_N     <= hsync_n_next;
      VSYNC_N     <= vsync_n_next;
      HBLANK      <= hblank_next;
      VBLANK      <= vblank_next;
      COMP_SYNC_N <= comp_sync_n_next;
    end
  end

endmodule

// File: tb/tb_sync_chain_sequencer.sv
// tb_sync_chain_sequencer
// Self-checking bench with a reduced raster so that several frames fit in a
// short run. The H and V sync windows both run past the line/frame end, so
// clipping is exercised. The reference model counts enabled edges since reset.
// From that count it derives the pixel number, and from the pixel number it
// derives every output arithmetically.

module tb_sync_chain_sequencer;

  localparam int DIV = 2;
  localparam int HT  = 20;
  localparam int HA  = 12;
  localparam int HSS = 14;
  localparam int HSL = 8;
  localparam int VT  = 10;
  localparam int VA  = 7;
  localparam int VSS = 8;
  localparam int VSL = 4;

  logic       clk_drv = 1'b0;
  logic       rst_n   = 1'b0;
  logic       enable  = 1'b1;
  logic       pix_clk_n, pix_ce, hsync_n, vsync_n, hblank, vblank;
  logic       comp_sync_n, frame_start;
  logic [8:0] h_cnt, v_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  int n_edges = 0;
  bit ce_model = 1'b0;

  sync_chain_sequencer #(
    .DIV(DIV), .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS),
    .H_SYNC_LEN(HSL), .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS),
    .V_SYNC_LEN(VSL)
  ) dut (
    .CLK_DRV(clk_drv), .RST_N(rst_n), .ENABLE(enable),
    .PIX_CLK_N(pix_clk_n), .PIX_CE(pix_ce), .H_CNT(h_cnt), .V_CNT(v_cnt),
    .HSYNC_N(hsync_n), .VSYNC_N(vsync_n), .HBLANK(hblank), .VBLANK(vblank),
    .COMP_SYNC_N(comp_sync_n), .FRAME_START(frame_start)
  );

  always #5 clk_drv = ~clk_drv;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit en, input int cycles);
    repeat (cycles) begin
      @(negedge clk_drv);
      #1 enable = en;
    end
  endtask

  // Reference model: count enabled edges since reset, and note pixel falls
  always @(posedge clk_drv or negedge rst_n) begin
    if (!rst_n) begin
      n_edges  = 0;
      ce_model = 1'b0;
    end else if (enable) begin
      n_edges++;
      ce_model = (n_edges % (2 * DIV)) == DIV;
    end else begin
      ce_model = 1'b0;
    end
  end

  // Compare every output against the model on each falling CLK_DRV edge
  always @(negedge clk_drv) begin
    if (cmp_on) begin
      int p, h, v, hs, vs, cs;
      p  = (n_edges + DIV) / (2 * DIV);
      h  = p % HT;
      v  = (p / HT) % VT;
      hs = (h >= HSS && h < HSS + HSL) ? 0 : 1;
      vs = (v >= VSS && v < VSS + VSL) ? 0 : 1;
`ifdef SYNC_SERRATION_EN
      cs = (hs == vs) ? 1 : 0;
`else
      cs = hs & vs;
`endif
      checkOutput("m_pix_clk_n", int'(pix_clk_n), ((n_edges / DIV) % 2 == 0) ? 1 : 0);
      checkOutput("m_pix_ce", int'(pix_ce), int'(ce_model));
      checkOutput("m_h_cnt", int'(h_cnt), h);
      checkOutput("m_v_cnt", int'(v_cnt), v);
      checkOutput("m_hsync_n", int'(hsync_n), hs);
      checkOutput("m_vsync_n", int'(vsync_n), vs);
      checkOutput("m_hblank", int'(hblank), (h >= HA) ? 1 : 0);
      checkOutput("m_vblank", int'(vblank), (v >= VA) ? 1 : 0);
      checkOutput("m_comp_sync_n", int'(comp_sync_n), cs);
      checkOutput("m_frame_start", int'(frame_start),
                  (ce_model && h == 0 && v == 0) ? 1 : 0);
    end
  end

  // Directed phases followed by randomized ENABLE traffic
  initial begin
    int pclk_exp[4] = '{0, 1, 1, 0};
    int ce_exp[4]   = '{0, 0, 0, 1};
    int ce_cnt, hs_cnt, vs_cnt, hb_cnt, vb_cnt, cs_cnt, cyc, h_hold, v_hold;
    bit ok;

    cmp_on = 1'b1;
    repeat (3) @(negedge clk_drv);
    checkOutput("rst_h_cnt", int'(h_cnt), 0);
    checkOutput("rst_pix_clk_n", int'(pix_clk_n), 1);
    checkOutput("rst_comp_sync_n", int'(comp_sync_n), 1);
    #1 rst_n = 1'b1;

    // The first fall comes DIV edges after release
    @(negedge clk_drv);
    checkOutput("lit_ce_edge1", int'(pix_ce), 0);
    checkOutput("lit_pclk_edge1", int'(pix_clk_n), 1);
    @(negedge clk_drv);
    checkOutput("lit_ce_edge2", int'(pix_ce), 1);
    checkOutput("lit_h_edge2", int'(h_cnt), 1);
    checkOutput("lit_pclk_edge2", int'(pix_clk_n), 0);
    checkOutput("lit_fs_edge2", int'(frame_start), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_drv);
      checkOutput("lit_pclk_seq", int'(pix_clk_n), pclk_exp[i]);
      checkOutput("lit_ce_seq", int'(pix_ce), ce_exp[i]);
    end
    checkOutput("lit_h_edge6", int'(h_cnt), 2);

    // Wait for a frame start, then tally one whole frame of pixel strobes
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk_drv);
      ok = frame_start;
    end
    checkOutput("frame1_seen", int'(ok), 1);
    checkOutput("frame1_h0", int'(h_cnt), 0);
    checkOutput("frame1_v0", int'(v_cnt), 0);
    ce_cnt = 0; hs_cnt = 0; vs_cnt = 0; hb_cnt = 0; vb_cnt = 0; cs_cnt = 0;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk_drv);
      if (pix_ce) begin
        ce_cnt++;
        if (!hsync_n && v_cnt == 9'd0) hs_cnt++;
        if (!vsync_n) vs_cnt++;
        if (hblank) hb_cnt++;
        if (vblank) vb_cnt++;
        if (!comp_sync_n) cs_cnt++;
      end
      ok = frame_start;
    end
    checkOutput("frame2_seen", int'(ok), 1);
    checkOutput("frame_ce_count", ce_cnt, 200);
    checkOutput("line_hsync_clipped", hs_cnt, 6);
    checkOutput("frame_vsync_clipped", vs_cnt, 40);
    checkOutput("frame_hblank", hb_cnt, 80);
    checkOutput("frame_vblank", vb_cnt, 60);
`ifdef SYNC_SERRATION_EN
    checkOutput("frame_comp_sync", cs_cnt, 76);
`else
    checkOutput("frame_comp_sync", cs_cnt, 88);
`endif

    // Freeze for 10 cycles just after the pixel at H=5
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk_drv);
      ok = pix_ce && (h_cnt == 9'd5);
    end
    checkOutput("hold_h5_seen", int'(ok), 1);
    h_hold = int'(h_cnt);
    v_hold = int'(v_cnt);
    #1 enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_drv);
      checkOutput("hold_no_ce", int'(pix_ce), 0);
    end
    checkOutput("hold_h", int'(h_cnt), 5);
    checkOutput("hold_pclk", int'(pix_clk_n), 0);
    #1 enable = 1'b1;
    cyc = 0;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk_drv);
      cyc++;
      ok = pix_ce;
    end
    checkOutput("resume_cycles", cyc, 4);
    checkOutput("resume_h", int'(h_cnt), h_hold + 1);
    checkOutput("resume_v", int'(v_cnt), v_hold);

    // Randomized ENABLE gating
    for (int i = 0; i < 1500; i++)
      applyStimulus($urandom_range(0, 9) != 0, 1);
    applyStimulus(1'b1, 1);

    // Asynchronous reset in the middle of hsync
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk_drv);
      ok = !hsync_n && (h_cnt == 9'd15);
    end
    checkOutput("hsync_seen", int'(ok), 1);
    @(posedge clk_drv);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_h_cnt", int'(h_cnt), 0);
    checkOutput("async_hsync_n", int'(hsync_n), 1);
    checkOutput("async_pclk", int'(pix_clk_n), 1);
    checkOutput("async_pix_ce", int'(pix_ce), 0);
    checkOutput("async_comp_sync_n", int'(comp_sync_n), 1);
    repeat (2) @(negedge clk_drv);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 600; i++)
      applyStimulus($urandom_range(0, 7) != 0, 1);

    @(negedge clk_drv);
    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_chain_sequencer.md
Name: sync_chain_sequencer

Overview:
- Sequences the emulated TTL video timing chain for the discrete-logic arcade cores.
- Divides fast CLK_DRV into a square-wave pixel clock, PIX_CLK_N, that feeds the CLK_N inputs of the toggle flip-flop counter stages.
- Keeps a registered master H/V count, aligned to every PIX_CLK_N falling edge, and decodes sync, blank and frame strobes from it.
- Game logic (paddles, score, sprites) takes its timing from these outputs instead of from the ripple chain.

Parameters:
- DIV, 2: CLK_DRV cycles per PIX_CLK_N half-period; must be >= 1.
- H_TOTAL, 454: pixel clocks per line; H_CNT range is 0..H_TOTAL-1.
- H_ACTIVE, 384: visible pixels per line, H_CNT 0..H_ACTIVE-1.
- H_SYNC_START, 400: first H_CNT with HSYNC_N low.
- H_SYNC_LEN, 32: HSYNC_N low width, in pixel clocks.
- V_TOTAL, 262: lines per frame.
- V_ACTIVE, 240: visible lines.
- V_SYNC_START, 244: first V_CNT with VSYNC_N low.
- V_SYNC_LEN, 4: VSYNC_N low width, in lines.

Ports:
- CLK_DRV, in, 1: single fast system clock; all state changes on its rising edge.
- RST_N, in, 1: asynchronous active-low reset.
- ENABLE, in, 1: high = run; low = freeze all state.
- PIX_CLK_N, out, 1: pixel clock square wave for downstream CLK_N inputs.
- PIX_CE, out, 1: one-CLK_DRV-cycle strobe in the cycle after each PIX_CLK_N fall.
- H_CNT, out, 9: horizontal count.
- V_CNT, out, 9: vertical count.
- HSYNC_N, out, 1: active-low horizontal sync.
- VSYNC_N, out, 1: active-low vertical sync.
- HBLANK, out, 1: high when H_CNT >= H_ACTIVE.
- VBLANK, out, 1: high when V_CNT >= V_ACTIVE.
- COMP_SYNC_N, out, 1: active-low composite sync.
- FRAME_START, out, 1: one-cycle strobe when H_CNT and V_CNT both wrap to 0.

Behaviour:
- Reset values (async assert, any time, including mid-line): DIV_CNT=0, PIX_CLK_N=1, PIX_CE=0, H_CNT=0, V_CNT=0, HSYNC_N=1, VSYNC_N=1, HBLANK=0, VBLANK=0, COMP_SYNC_N=1, FRAME_START=0.
- All outputs are registered; no combinational path from any input to any output.
- Divider, on each rising edge with ENABLE=1:
  - if DIV_CNT==DIV-1, DIV_CNT becomes 0 and PIX_CLK_N toggles;
  - otherwise DIV_CNT increments.
  - PIX_CLK_N period = 2*DIV CLK_DRV cycles, 50% duty.
- Fall edge: the edge where PIX_CLK_N registers 1->0. On that same edge:
  - PIX_CE registers 1 (0 on every other edge);
  - H_CNT and V_CNT advance;
  - all decoded outputs update to match the new counts.
- Count rules on a fall edge:
  - H_CNT==H_TOTAL-1 -> H_CNT=0 and V_CNT advances; otherwise H_CNT+1.
  - V_CNT advances as V_TOTAL-1 -> 0, otherwise +1.
- Decoded outputs always describe the current H_CNT/V_CNT, so there is zero latency between counts and decodes:
  - HSYNC_N=0 iff H_SYNC_START <= H_CNT < H_SYNC_START+H_SYNC_LEN.
  - VSYNC_N=0 iff V_SYNC_START <= V_CNT < V_SYNC_START+V_SYNC_LEN.
  - HBLANK and VBLANK as defined under Ports.
- FRAME_START=1 only on the fall edge that produces H=0,V=0, so it coincides with that PIX_CE. It is not asserted on reset release.
- ENABLE=0: DIV_CNT, PIX_CLK_N and the counters hold; PIX_CE=0 and FRAME_START=0. A PIX_CE that was high clears on the next edge.
- ENABLE rising: the divider continues from its held DIV_CNT; there is no phase reset.
- Reset release: the first PIX_CLK_N fall occurs DIV enabled edges after release, since PIX_CLK_N starts at 1.
- Sync windows that run past H_TOTAL or V_TOTAL are clipped, not wrapped.

Optional Feature:
- Macro: SYNC_SERRATION_EN.
- Defined: COMP_SYNC_N = HSYNC_N XNOR VSYNC_N. Outside vsync, COMP_SYNC_N follows HSYNC_N; during vsync it is inverted, producing serration pulses.
- Undefined: COMP_SYNC_N = HSYNC_N AND VSYNC_N, with no serration.
- In both cases COMP_SYNC_N is registered and updates on the fall edge together with the other decodes.

Test Plan:
- Reset, DIV=2, ENABLE=1: PIX_CLK_N falls on the 2nd edge after release with PIX_CE=1 and H_CNT=1. PIX_CE then repeats every 4 cycles; PIX_CLK_N is low 2 cycles and high 2 cycles.
- Run one full line: H_CNT steps 453 -> 0 with V_CNT 0 -> 1. HBLANK rises at H=384. HSYNC_N is low for exactly H=400..431 (32 PIX_CE).
- Run a full frame: VSYNC_N is low for V=244..247. VBLANK is high for V=240..261. FRAME_START fires exactly once, on the wrap to (0,0), and 454*262 PIX_CE strobes separate consecutive FRAME_START pulses.
- Drop ENABLE for 10 cycles mid-line at H=100: all counts and PIX_CLK_N hold and no PIX_CE occurs. After ENABLE returns, the next fall comes at the remaining divider phase and H=101.
- Assert RST_N low asynchronously between edges at H=420 (HSYNC_N=0): all outputs take their reset values immediately, HSYNC_N=1 and H_CNT=0.
- With SYNC_SERRATION_EN defined, at V=245, H=410: COMP_SYNC_N=1. At V=245, H=100: COMP_SYNC_N=0. Without the macro, COMP_SYNC_N=0 for the whole of V=244..247.
